and_8: RTL and testbench

AND_8 -- requirements
Module: and_8

---
 rtl/and_8_pkg.sv | 14 +
 rtl/and_8_popcnt.sv | 19 +
 rtl/and_8.sv | 77 +++++++
 tb/tb_and_8.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/and_8_pkg.sv
// Shared constants and types for the and_8 block.
//   IN_W      operand width
//   ALL_ONES  the only operand value for which the AND reduction is 1
//   operand_t operand vector type
//   popcnt_t  set-bit count type, wide enough for 0..IN_W
package and_8_pkg;

  localparam int unsigned IN_W = 8;
  localparam logic [IN_W-1:0] ALL_ONES = 8'hFF;

  typedef logic [IN_W-1:0] operand_t;
  typedef logic [3:0]      popcnt_t;

endpackage

// File: rtl/and_8_popcnt.sv
// Combinational population count of an operand vector.
// Ports:
//   a    operand vector
//   cnt  number of set bits in a (0..8)
module and_8_popcnt
  import and_8_pkg::*;
(
  input  operand_t a,
  output popcnt_t  cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < int'(IN_W); i++) begin
      cnt = cnt + popcnt_t'(a[i]);
    end
  end

endmodule

// File: rtl/and_8.sv
// 8-input AND reduction with a registered copy, rising-edge pulse and optional
// statistics (popcount of the sampled operand and a saturating hit counter).
// Statistics logic is built only when the macro AND_8_STATS_EN is defined;
// otherwise ones_cnt and hit_cnt are constant 0 and carry no flops.
// Ports:
//   clk       single clock, rising-edge active
//   rst_n     synchronous active-low reset
//   a         operand vector, a[0] is the LSB
//   b         combinational AND of all bits of a
//   en        sample enable for the registered path
//   b_q       registered copy of b (loads when en=1)
//   b_rise    registered pulse, high for the cycle in which b_q first reads 1
//   ones_cnt  registered popcount of a (loads when en=1)
//   hit_cnt   saturating count of enabled edges with b=1
module and_8
  import and_8_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  operand_t         a,
  output logic             b,
  input  logic             en,
  output logic             b_q,
  output logic             b_rise,
  output popcnt_t          ones_cnt,
  output logic [CNT_W-1:0] hit_cnt
);

  // Pure reduction: no dependence on clock, reset or enable.
  assign b = (a == ALL_ONES);

  // b_rise is computed from the value b_q is about to take, so the pulse lines
  // up with the first cycle b_q reads 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_q    <= 1'b0;
      b_rise <= 1'b0;
    end else begin
      b_rise <= en & b & ~b_q;
      if (en) begin
        b_q <= b;
      end
    end
  end

`ifdef AND_8_STATS_EN
  popcnt_t ones_now;

  and_8_popcnt u_popcnt (
    .a   (a),
    .cnt (ones_now)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ones_cnt <= '0;
    end else if (en) begin
      ones_cnt <= ones_now;
    end
  end

  // Saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (en && b && (hit_cnt != {CNT_W{1'b1}})) begin
      hit_cnt <= hit_cnt + CNT_W'(1);
    end
  end
`else
  assign ones_cnt = '0;
  assign hit_cnt  = '0;
`endif

endmodule

// File: tb/tb_and_8.sv
// Self-checking bench for and_8: directed steps plus randomized operands,
// checked against a behavioural model of the observable rules.
module tb_and_8;

`ifdef AND_8_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a;
  logic        en;
  logic        b, b_q, b_rise;
  logic [3:0]  ones_cnt;
  logic [15:0] hit_cnt;
  logic        b2, b_q2, b_rise2;
  logic [3:0]  ones_cnt2;
  logic [1:0]  hit_cnt2;

  always #5 clk = ~clk;

  and_8 #(.CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .en       (en),
    .b_q      (b_q),
    .b_rise   (b_rise),
    .ones_cnt (ones_cnt),
    .hit_cnt  (hit_cnt)
  );

  and_8 #(.CNT_W(2)) dut_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b2),
    .en       (en),
    .b_q      (b_q2),
    .b_rise   (b_rise2),
    .ones_cnt (ones_cnt2),
    .hit_cnt  (hit_cnt2)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  bit m_bq;
  bit m_rise;
  int m_ones;
  int m_hit;
  int m_hit2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, check b, advance model on the edge,
  // then check every registered output just after the edge.
  task automatic cycle(input logic [7:0] av, input logic env, input logic rv);
    bit old_bq;
    bit all_set;
    @(negedge clk);
    a     = av;
    en    = env;
    rst_n = rv;
    all_set = (av == 8'hFF);
    #1;
    chk("b_comb", {31'd0, b}, {31'd0, all_set});
    @(posedge clk);
    if (!rv) begin
      m_bq = 0; m_rise = 0; m_ones = 0; m_hit = 0; m_hit2 = 0;
    end else begin
      old_bq = m_bq;
      if (env) begin
        m_bq   = all_set;
        m_ones = $countones(av);
        if (all_set) begin
          if (m_hit < 65535) m_hit = m_hit + 1;
          if (m_hit2 < 3)    m_hit2 = m_hit2 + 1;
        end
      end
      m_rise = m_bq && !old_bq;
    end
    #1;
    chk("b_after_edge", {31'd0, b},       {31'd0, all_set});
    chk("b_q",          {31'd0, b_q},     {31'd0, m_bq});
    chk("b_rise",       {31'd0, b_rise},  {31'd0, m_rise});
    chk("ones_cnt",     {28'd0, ones_cnt}, Stats ? m_ones : 0);
    chk("hit_cnt",      {16'd0, hit_cnt},  Stats ? m_hit : 0);
    chk("b_q_w2",       {31'd0, b_q2},    {31'd0, m_bq});
    chk("b_rise_w2",    {31'd0, b_rise2}, {31'd0, m_rise});
    chk("hit_cnt_w2",   {30'd0, hit_cnt2}, Stats ? m_hit2 : 0);
  endtask

  initial begin
    logic [7:0] walk [8];
    logic [7:0] rv8;
    int rises;
    walk = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    a = 8'h00; en = 1'b0; rst_n = 1'b0;
    m_bq = 0; m_rise = 0; m_ones = 0; m_hit = 0; m_hit2 = 0;

    // Reset state
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);

    // All zeros sampled
    cycle(8'h00, 1'b1, 1'b1);

    // Walking accumulate, each value held two cycles; count rise pulses seen
    rises = 0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 2; j++) begin
        cycle(walk[i], 1'b1, 1'b1);
        if (b_rise === 1'b1) rises++;
      end
    end
    chk("walk_rise_count", rises, 1);
    chk("walk_ones_final", {28'd0, ones_cnt}, Stats ? 8 : 0);

    // Enable low: registers hold while a changes
    for (int i = 0; i < 3; i++) cycle(8'h0F, 1'b0, 1'b1);
    chk("hold_b_q", {31'd0, b_q}, 1);

    // Ten enabled all-ones cycles, then reset with enable still high
    cycle(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(8'hFF, 1'b1, 1'b1);
    chk("hit_reaches_10", {16'd0, hit_cnt},  Stats ? 10 : 0);
    chk("hit_w2_sat",     {30'd0, hit_cnt2}, Stats ? 3 : 0);
    cycle(8'hFF, 1'b1, 1'b0);
    chk("rst_b_stays_1", {31'd0, b}, 1);
    chk("rst_hit_clear", {16'd0, hit_cnt}, 0);
    // First enabled edge after release resumes sampling
    cycle(8'hFF, 1'b1, 1'b1);

    // Random operands, each held two cycles, enable high
    for (int i = 0; i < 3000; i++) begin
      rv8 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      cycle(rv8, 1'b1, 1'b1);
      cycle(rv8, 1'b1, 1'b1);
    end

    // Random operands with random enable and occasional reset
    for (int i = 0; i < 600; i++) begin
      rv8 = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      cycle(rv8, 1'($urandom_range(0, 1)), ($urandom_range(0, 40) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
